// File: rtl/scratchpad_dma_engine_pkg.sv
// ============================================================================
// scratchpad_dma_engine_pkg : shared types and constants for the scratchpad DMA
// Revision: 1.0
// ============================================================================
`default_nettype none

package scratchpad_dma_engine_pkg;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_WRITE = 3'd1,
        ST_READ  = 3'd2,
        ST_DRAIN = 3'd3,
        ST_DONE  = 3'd4
    } dma_state_e;

    localparam logic DIR_WRITE = 1'b0;
    localparam logic DIR_READ  = 1'b1;

    localparam int BANK_WGT = 0;
    localparam int BANK_ACT = 1;

    localparam int FIFO_DEPTH = 2;

endpackage

`default_nettype wire

// File: rtl/scratchpad_dma_engine_skid_fifo.sv
// ============================================================================
// dma_skid_fifo : 2-entry valid/ready FIFO with synchronous flush
// Revision: 1.0
// ============================================================================
`default_nettype none

module dma_skid_fifo #(
    parameter int DATA_WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  flush,
    input  logic [DATA_WIDTH-1:0] s_tdata,
    input  logic                  s_tvalid,
    output logic                  s_tready,
    output logic [DATA_WIDTH-1:0] m_tdata,
    output logic                  m_tvalid,
    input  logic                  m_tready,
    output logic [1:0]            count
);

    logic [DATA_WIDTH-1:0] slot_q [2];
    logic [DATA_WIDTH-1:0] slot_d [2];
    logic                  wr_ptr_q, wr_ptr_d;
    logic                  rd_ptr_q, rd_ptr_d;
    logic [1:0]            count_q,  count_d;
    logic                  push, pop;

    assign s_tready = (count_q != 2'd2);
    assign m_tvalid = (count_q != 2'd0);
    assign m_tdata  = slot_q[rd_ptr_q];
    assign count    = count_q;
    assign push     = s_tvalid && s_tready;
    assign pop      = m_tvalid && m_tready;

    always_comb begin
        slot_d   = slot_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (flush) begin
            wr_ptr_d = 1'b0;
            rd_ptr_d = 1'b0;
            count_d  = 2'd0;
        end else begin
            if (push) begin
                slot_d[wr_ptr_q] = s_tdata;
                wr_ptr_d         = ~wr_ptr_q;
            end
            if (pop) begin
                rd_ptr_d = ~rd_ptr_q;
            end
            count_d = count_q + {1'b0, push} - {1'b0, pop};
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            slot_q[0] <= '0;
            slot_q[1] <= '0;
            wr_ptr_q  <= 1'b0;
            rd_ptr_q  <= 1'b0;
            count_q   <= 2'd0;
        end else begin
            slot_q    <= slot_d;
            wr_ptr_q  <= wr_ptr_d;
            rd_ptr_q  <= rd_ptr_d;
            count_q   <= count_d;
        end
    end

endmodule

`default_nettype wire

// File: rtl/scratchpad_dma_engine.sv
// ============================================================================
// scratchpad_dma_engine : host stream <-> banked scratchpad SRAM DMA engine
// Revision: 1.0
// ============================================================================
`default_nettype none

module scratchpad_dma_engine
    import scratchpad_dma_engine_pkg::*;
#(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 10,
    parameter int NUM_BANKS  = 2,
    parameter int LEN_WIDTH  = 11,
    localparam int BANK_W    = (NUM_BANKS > 1) ? $clog2(NUM_BANKS) : 1
) (
    input  logic                            clk,
    input  logic                            rst_n,
    input  logic                            cfg_start,
    input  logic                            cfg_dir,
    input  logic [BANK_W-1:0]               cfg_bank,
    input  logic [ADDR_WIDTH-1:0]           cfg_base,
    input  logic [LEN_WIDTH-1:0]            cfg_len,
    input  logic                            cfg_abort,
    output logic                            busy,
    output logic                            done,
    output logic                            err,
    output logic                            aborted,
    output logic [LEN_WIDTH-1:0]            words_done,
    input  logic [DATA_WIDTH-1:0]           s_tdata,
    input  logic                            s_tvalid,
    output logic                            s_tready,
    output logic [DATA_WIDTH-1:0]           m_tdata,
    output logic                            m_tvalid,
    input  logic                            m_tready,
    output logic [NUM_BANKS-1:0]            mem_we,
    output logic [NUM_BANKS-1:0]            mem_re,
    output logic [ADDR_WIDTH-1:0]           mem_addr,
    output logic [DATA_WIDTH-1:0]           mem_wdata,
    input  logic [NUM_BANKS*DATA_WIDTH-1:0] mem_rdata
);

    localparam int DEPTH = 1 << ADDR_WIDTH;
    localparam int SUM_W = LEN_WIDTH + 1;

    dma_state_e              state_q,    state_d;
    logic                    dir_q,      dir_d;
    logic [BANK_W-1:0]       bank_q,     bank_d;
    logic [ADDR_WIDTH-1:0]   addr_q,     addr_d;
    logic [LEN_WIDTH-1:0]    remain_q,   remain_d;
    logic [LEN_WIDTH-1:0]    words_q,    words_d;
    logic                    err_q,      err_d;
    logic                    aborted_q,  aborted_d;
    logic [NUM_BANKS-1:0]    we_q,       we_d;
    logic [ADDR_WIDTH-1:0]   waddr_q,    waddr_d;
    logic [DATA_WIDTH-1:0]   wdata_q,    wdata_d;
    logic                    inflight_q, inflight_d;

    logic [DATA_WIDTH-1:0]   bank_rdata [NUM_BANKS];
    logic [NUM_BANKS-1:0]    bank_sel;
    logic [SUM_W-1:0]        span;
    logic                    range_err;
    logic                    active, abort_now, m_hs, rd_issue;
    logic                    fifo_push, fifo_in_ready;
    logic [1:0]              fifo_count, occ_after_pop;

    for (genvar b = 0; b < NUM_BANKS; b++) begin : g_bank
        assign bank_rdata[b] = mem_rdata[b*DATA_WIDTH +: DATA_WIDTH];
    end

    assign bank_sel  = NUM_BANKS'(1) << bank_q;
    assign span      = SUM_W'(cfg_base) + SUM_W'(cfg_len);
    assign range_err = span > SUM_W'(DEPTH);

    assign active    = (state_q == ST_WRITE) || (state_q == ST_READ) || (state_q == ST_DRAIN);
    assign abort_now = cfg_abort && active;
    assign m_hs      = m_tvalid && m_tready;

    // Occupancy counts the beat leaving this cycle so a 2-entry FIFO can sustain 1 word/cycle.
    assign occ_after_pop = fifo_count - {1'b0, m_hs};
    assign rd_issue  = (state_q == ST_READ) && !cfg_abort &&
                       (({1'b0, occ_after_pop} + {2'b0, inflight_q}) < 3'(FIFO_DEPTH));

    // Returning read data is dropped once the transfer has been aborted.
    assign fifo_push = inflight_q && fifo_in_ready && !cfg_abort &&
                       ((state_q == ST_READ) || (state_q == ST_DRAIN));

    dma_skid_fifo #(
        .DATA_WIDTH (DATA_WIDTH)
    ) u_fifo (
        .clk      (clk),
        .rst_n    (rst_n),
        .flush    (abort_now),
        .s_tdata  (bank_rdata[bank_q]),
        .s_tvalid (fifo_push),
        .s_tready (fifo_in_ready),
        .m_tdata  (m_tdata),
        .m_tvalid (m_tvalid),
        .m_tready (m_tready),
        .count    (fifo_count)
    );

    assign busy       = (state_q != ST_IDLE);
    assign done       = (state_q == ST_DONE);
    assign err        = err_q;
    assign aborted    = aborted_q;
    assign words_done = words_q;
    assign s_tready   = (state_q == ST_WRITE);
    assign mem_we     = we_q;
    assign mem_re     = rd_issue ? bank_sel : '0;
    assign mem_addr   = (state_q == ST_READ) ? addr_q : waddr_q;
    assign mem_wdata  = wdata_q;

    always_comb begin
        state_d    = state_q;
        dir_d      = dir_q;
        bank_d     = bank_q;
        addr_d     = addr_q;
        remain_d   = remain_q;
        words_d    = words_q;
        err_d      = err_q;
        aborted_d  = aborted_q;
        we_d       = '0;
        waddr_d    = waddr_q;
        wdata_d    = wdata_q;
        inflight_d = rd_issue;

        case (state_q)
            ST_IDLE: begin
                if (cfg_start) begin
                    err_d     = 1'b0;
                    aborted_d = 1'b0;
                    words_d   = '0;
                    dir_d     = cfg_dir;
                    bank_d    = cfg_bank;
                    addr_d    = cfg_base;
                    remain_d  = cfg_len;
                    if (range_err) begin
                        err_d   = 1'b1;
                        state_d = ST_DONE;
                    end else if (cfg_len == '0) begin
                        state_d = ST_DONE;
                    end else if (cfg_dir == DIR_READ) begin
                        state_d = ST_READ;
                    end else begin
                        state_d = ST_WRITE;
                    end
                end
            end
            ST_WRITE: begin
                if (abort_now) begin
                    aborted_d = 1'b1;
                    state_d   = ST_DONE;
                end else if (s_tvalid) begin
                    we_d     = bank_sel;
                    waddr_d  = addr_q;
                    wdata_d  = s_tdata;
                    addr_d   = addr_q + ADDR_WIDTH'(1);
                    words_d  = words_q + LEN_WIDTH'(1);
                    remain_d = remain_q - LEN_WIDTH'(1);
                    if (remain_q == LEN_WIDTH'(1)) begin
                        state_d = ST_DONE;
                    end
                end
            end
            ST_READ, ST_DRAIN: begin
                if (m_hs) begin
                    words_d = words_q + LEN_WIDTH'(1);
                end
                if (abort_now) begin
                    aborted_d = 1'b1;
                    state_d   = ST_DONE;
                end else if (state_q == ST_READ) begin
                    if (rd_issue) begin
                        addr_d   = addr_q + ADDR_WIDTH'(1);
                        remain_d = remain_q - LEN_WIDTH'(1);
                        if (remain_q == LEN_WIDTH'(1)) begin
                            state_d = ST_DRAIN;
                        end
                    end
                end else if ((occ_after_pop == 2'd0) && !inflight_q) begin
                    state_d = ST_DONE;
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= ST_IDLE;
            dir_q      <= DIR_WRITE;
            bank_q     <= '0;
            addr_q     <= '0;
            remain_q   <= '0;
            words_q    <= '0;
            err_q      <= 1'b0;
            aborted_q  <= 1'b0;
            we_q       <= '0;
            waddr_q    <= '0;
            wdata_q    <= '0;
            inflight_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            dir_q      <= dir_d;
            bank_q     <= bank_d;
            addr_q     <= addr_d;
            remain_q   <= remain_d;
            words_q    <= words_d;
            err_q      <= err_d;
            aborted_q  <= aborted_d;
            we_q       <= we_d;
            waddr_q    <= waddr_d;
            wdata_q    <= wdata_d;
            inflight_q <= inflight_d;
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_scratchpad_dma_engine.sv
// ============================================================================
// tb_scratchpad_dma_engine : randomized self-checking bench with SRAM model
// Revision: 1.0
// ============================================================================
`default_nettype none

module tb_scratchpad_dma_engine;
    import scratchpad_dma_engine_pkg::*;

    localparam int DW    = 32;
    localparam int AW    = 10;
    localparam int NB    = 2;
    localparam int LW    = 11;
    localparam int DEPTH = 1 << AW;

    logic            clk = 1'b0;
    logic            rst_n = 1'b0;
    logic            cfg_start = 1'b0, cfg_dir = 1'b0, cfg_abort = 1'b0;
    logic [0:0]      cfg_bank = '0;
    logic [AW-1:0]   cfg_base = '0;
    logic [LW-1:0]   cfg_len = '0;
    logic [DW-1:0]   s_tdata = '0;
    logic            s_tvalid = 1'b0, m_tready = 1'b0;
    logic            busy, done, err, aborted, s_tready, m_tvalid;
    logic [LW-1:0]   words_done;
    logic [DW-1:0]   m_tdata, mem_wdata;
    logic [NB-1:0]   mem_we, mem_re;
    logic [AW-1:0]   mem_addr;
    logic [NB*DW-1:0] mem_rdata;

    always #5 clk = ~clk;

    scratchpad_dma_engine #(
        .DATA_WIDTH(DW), .ADDR_WIDTH(AW), .NUM_BANKS(NB), .LEN_WIDTH(LW)
    ) dut (
        .clk(clk), .rst_n(rst_n), .cfg_start(cfg_start), .cfg_dir(cfg_dir),
        .cfg_bank(cfg_bank), .cfg_base(cfg_base), .cfg_len(cfg_len), .cfg_abort(cfg_abort),
        .busy(busy), .done(done), .err(err), .aborted(aborted), .words_done(words_done),
        .s_tdata(s_tdata), .s_tvalid(s_tvalid), .s_tready(s_tready),
        .m_tdata(m_tdata), .m_tvalid(m_tvalid), .m_tready(m_tready),
        .mem_we(mem_we), .mem_re(mem_re), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata)
    );

    function automatic logic [DW-1:0] init_word(input int b, input int a);
        return 32'(b * DEPTH + a) * 32'h9E3779B1 + 32'h01234567;
    endfunction

    // SRAM banks attached to the DUT, one-cycle read latency
    logic [DW-1:0] ram    [NB][DEPTH];
    logic [DW-1:0] ram_rd [NB];
    logic          ram_init = 1'b1;

    always @(posedge clk) begin
        if (ram_init) begin
            for (int b = 0; b < NB; b++)
                for (int a = 0; a < DEPTH; a++)
                    ram[b][a] <= init_word(b, a);
        end else begin
            for (int b = 0; b < NB; b++) begin
                if (mem_we[b]) ram[b][mem_addr] <= mem_wdata;
                if (mem_re[b]) ram_rd[b] <= ram[b][mem_addr];
            end
        end
    end

    always_comb begin
        for (int b = 0; b < NB; b++) mem_rdata[b*DW +: DW] = ram_rd[b];
    end

    int done_cnt = 0, we_cnt = 0, re_cnt = 0;
    always @(posedge clk) begin
        if (done)    done_cnt++;
        if (|mem_we) we_cnt++;
        if (|mem_re) re_cnt++;
    end

    // Reference model: expected memory image
    logic [DW-1:0] exp_ram [NB][DEPTH];

    int n_checks = 0, n_errors = 0;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic start_xfer(input logic dir, input int bank, input int base, input int len);
        cfg_start = 1'b1;
        cfg_dir   = dir;
        cfg_bank  = bank[0:0];
        cfg_base  = base[AW-1:0];
        cfg_len   = len[LW-1:0];
        tick();
        cfg_start = 1'b0;
    endtask

    task automatic wait_done(input string tag, input int d0);
        int k = 0;
        while (done_cnt == d0 && k < 300) begin
            tick();
            k++;
        end
        chk({tag, "_done_seen"}, done_cnt > d0, 1);
        tick();
        chk({tag, "_done_pulses"}, done_cnt - d0, 1);
        chk({tag, "_idle"}, busy, 0);
    endtask

    task automatic ram_image(input string tag);
        int mism = 0;
        for (int b = 0; b < NB; b++)
            for (int a = 0; a < DEPTH; a++)
                if (ram[b][a] !== exp_ram[b][a]) mism++;
        chk({tag, "_ram_image"}, mism, 0);
    endtask

    task automatic do_write(input string tag, input int bank, input int base,
                            input logic [DW-1:0] data [$], input bit gapped, input bit poke);
        int d0 = done_cnt;
        int i = 0;
        int budget = 0;
        bit hs;
        start_xfer(DIR_WRITE, bank, base, data.size());
        while (i < data.size() && budget < 500) begin
            s_tvalid = gapped ? 1'($urandom_range(0, 1)) : 1'b1;
            s_tdata  = data[i];
            if (poke && budget == 1) begin
                cfg_start = 1'b1; cfg_dir = DIR_READ; cfg_base = '0; cfg_len = 11'd5;
            end
            hs = s_tvalid && s_tready;
            tick();
            cfg_start = 1'b0;
            if (hs) i++;
            budget++;
        end
        s_tvalid = 1'b0;
        for (int k = 0; k < data.size(); k++) exp_ram[bank][base + k] = data[k];
        wait_done(tag, d0);
        chk({tag, "_words"}, words_done, data.size());
        chk({tag, "_err"}, {err, aborted}, 0);
    endtask

    task automatic do_read(input string tag, input int bank, input int base, input int len,
                           input bit full_rate, output int span);
        int d0 = done_cnt;
        int cyc = 0, first = -1, last = -1, viol = 0;
        bit prev_stall = 0;
        logic [DW-1:0] prev_data = '0;
        logic [DW-1:0] got [$];
        start_xfer(DIR_READ, bank, base, len);
        while (done_cnt == d0 && cyc < 2000) begin
            m_tready = full_rate ? 1'b1 : 1'($urandom_range(0, 1));
            if (prev_stall && (!m_tvalid || m_tdata !== prev_data)) viol++;
            if (m_tvalid && m_tready) begin
                got.push_back(m_tdata);
                if (first < 0) first = cyc;
                last = cyc;
            end
            prev_stall = m_tvalid && !m_tready;
            prev_data  = m_tdata;
            tick();
            cyc++;
        end
        m_tready = 1'b0;
        chk({tag, "_done_seen"}, done_cnt > d0, 1);
        tick();
        chk({tag, "_beats"}, got.size(), len);
        for (int i = 0; i < got.size() && i < len; i++)
            chk({tag, "_data"}, got[i], exp_ram[bank][base + i]);
        chk({tag, "_stall_hold"}, viol, 0);
        chk({tag, "_words"}, words_done, len);
        span = last - first;
    endtask

    initial begin
        logic [DW-1:0] q [$];
        int span, we0, re0, d0, bank, base, len;
        logic [DW-1:0] got0, got1;

        for (int b = 0; b < NB; b++)
            for (int a = 0; a < DEPTH; a++)
                exp_ram[b][a] = init_word(b, a);

        repeat (3) tick();
        chk("reset_ctrl", {busy, done, err, aborted, s_tready, m_tvalid, mem_we, mem_re}, 0);
        chk("reset_words", words_done, 0);
        rst_n = 1'b1;
        ram_init = 1'b0;
        tick();

        q = {32'h02020202};
        do_write("wr_single", BANK_WGT, 0, q, 1'b0, 1'b0);
        chk("wr_single_ram", ram[BANK_WGT][0], 32'h02020202);

        q = {32'h0A0A0A0A, 32'h0B0B0B0B, 32'h0C0C0C0C, 32'h0D0D0D0D};
        do_write("wr_gapped", BANK_ACT, 512, q, 1'b1, 1'b0);
        ram_image("wr_gapped");

        do_read("rd_rand", BANK_ACT, 512, 4, 1'b0, span);
        do_read("rd_full", BANK_ACT, 512, 4, 1'b1, span);
        chk("rd_full_back_to_back", span, 3);

        we0 = we_cnt; re0 = re_cnt; d0 = done_cnt;
        start_xfer(DIR_READ, BANK_ACT, 1020, 8);
        chk("range_err_flag", err, 1);
        wait_done("range", d0);
        chk("range_no_strobes", (we_cnt - we0) + (re_cnt - re0), 0);

        d0 = done_cnt;
        start_xfer(DIR_WRITE, BANK_WGT, 5, 0);
        wait_done("len0", d0);
        chk("len0_err", err, 0);

        q = {32'h11111111, 32'h22222222, 32'h33333333};
        do_write("busy_start", BANK_WGT, 100, q, 1'b0, 1'b1);
        ram_image("busy_start");

        for (int r = 0; r < 6; r++) begin
            bank = $urandom_range(0, 1);
            len  = $urandom_range(1, 12);
            base = $urandom_range(0, DEPTH - len);
            q.delete();
            for (int k = 0; k < len; k++) q.push_back($urandom);
            do_write("rnd_wr", bank, base, q, 1'b1, 1'b0);
            do_read("rnd_rd", bank, base, len, 1'($urandom_range(0, 1)), span);
        end
        ram_image("rnd");

        we0 = we_cnt; d0 = done_cnt;
        base = $urandom_range(DEPTH - 8, DEPTH - 1);
        start_xfer(DIR_WRITE, BANK_WGT, base, $urandom_range(DEPTH - base + 1, DEPTH - base + 20));
        wait_done("rnd_range", d0);
        chk("rnd_range_err", err, 1);
        chk("rnd_range_no_we", we_cnt - we0, 0);

        // Abort a read with two beats delivered and the host stalled
        d0 = done_cnt;
        got0 = '0; got1 = '0;
        start_xfer(DIR_READ, BANK_ACT, 512, 8);
        for (int k = 0; k < 50 && words_done < 2; k++) begin
            m_tready = 1'b1;
            if (m_tvalid && words_done == 0) got0 = m_tdata;
            if (m_tvalid && words_done == 1) got1 = m_tdata;
            tick();
        end
        m_tready = 1'b0;
        repeat (3) tick();
        chk("abort_fifo_full", m_tvalid, 1);
        cfg_abort = 1'b1;
        tick();
        cfg_abort = 1'b0;
        re0 = re_cnt;
        chk("abort_m_tvalid", m_tvalid, 0);
        chk("abort_flags", {done, aborted}, 2'b11);
        chk("abort_words", words_done, 2);
        chk("abort_beat0", got0, exp_ram[BANK_ACT][512]);
        chk("abort_beat1", got1, exp_ram[BANK_ACT][513]);
        repeat (2) tick();
        chk("abort_no_more_re", re_cnt - re0, 0);
        chk("abort_done_pulses", done_cnt - d0, 1);
        chk("abort_idle", busy, 0);

        // Asynchronous reset in the middle of a write
        start_xfer(DIR_WRITE, BANK_WGT, 200, 6);
        s_tvalid = 1'b1;
        s_tdata  = 32'hDEADBEEF;
        repeat (2) tick();
        #2;
        rst_n = 1'b0;
        s_tvalid = 1'b0;
        #1;
        chk("rst_mid_ctrl", {busy, done, err, aborted, s_tready, m_tvalid, mem_we, mem_re}, 0);
        chk("rst_mid_bus", {mem_addr, mem_wdata}, 0);
        chk("rst_mid_words", words_done, 0);
        tick();
        rst_n = 1'b1;
        tick();
        q.delete();
        for (int k = 0; k < 6; k++) q.push_back($urandom);
        do_write("post_rst", BANK_WGT, 200, q, 1'b1, 1'b0);
        do_read("post_rst_rd", BANK_WGT, 200, 6, 1'b0, span);
        ram_image("final");

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish, %0d checks so far", n_checks);
        $fatal(1);
    end

endmodule

`default_nettype wire
